ecc_dec_pipe: RTL and testbench

- Pipelined extended-Hamming (SECDED) decoder for noisy codewords.
- Supports runtime-selectable codeword lengths of 8, 16 and 32 bits.
- Computes the syndrome, corrects single-bit errors, flags double-bit errors and outputs the packed data bits.
- Sits between the noisy-channel register stage and the data consumer, using a valid/ready handshake on both sides.

---
 rtl/ecc_dec_pipe.sv | 236 +++++++++++++++++++++++
 tb/tb_ecc_dec_pipe.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_dec_pipe.sv
// ecc_dec_pipe: two-stage pipelined extended-Hamming (SECDED) decoder
// for 8/16/32-bit codewords selected per word by mode.
// Ports: clk, rst (async, active high); input side in_valid/in_ready,
//   NoisyCodeWord, mode; output side out_valid/out_ready, data_out,
//   num_of_errors, syndrome.
// Optional macro ECC_DEC_STATS_EN adds stat_clr, corr_cnt, uncorr_cnt
//   (saturating 16-bit corrected/uncorrectable word counters).
module ecc_dec_pipe #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] NoisyCodeWord,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            num_of_errors,
  output logic [5:0]            syndrome
`ifdef ECC_DEC_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [15:0]           corr_cnt,
  output logic [15:0]           uncorr_cnt
`endif
);

  // H column of codeword bit k for an m-bit low syndrome: powers of two
  // for the check bits, 0 for the overall parity bit, then the remaining
  // non-power-of-two values in ascending order for the data bits.
  function automatic logic [4:0] hcol(input int k, input int m);
    logic [4:0] r;
    int cnt;
    r   = '0;
    cnt = m + 1;
    if (k < m) begin
      r = 5'(1 << k);
    end else if (k > m) begin
      for (int v = 3; v < 32; v++) begin
        if ((v & (v - 1)) != 0) begin
          if (cnt == k) r = 5'(v);
          cnt++;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [31:0][4:0] cols_tab(input int m);
    logic [31:0][4:0] t;
    for (int k = 0; k < 32; k++) t[k] = hcol(k, m);
    return t;
  endfunction

  localparam logic [31:0][4:0] COL3 = cols_tab(3);
  localparam logic [31:0][4:0] COL4 = cols_tab(4);
  localparam logic [31:0][4:0] COL5 = cols_tab(5);

  // Returns {p, s_low} zero-extended to 6 bits.
  function automatic logic [5:0] syn_calc(
    input logic [31:0]       cw,
    input int                n,
    input int                m,
    input logic [31:0][4:0]  tab
  );
    logic [4:0] s;
    logic       p;
    logic [5:0] r;
    s = '0;
    p = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k < n && cw[k]) begin
        s = s ^ tab[k];
        p = ~p;
      end
    end
    r    = 6'(s);
    r[m] = p;
    return r;
  endfunction

  // Flip the bit whose column matches s_low when overall parity fails,
  // then pack the data bits down to bit 0.
  function automatic logic [31:0] dec_data(
    input logic [31:0]       cw,
    input logic [5:0]        syn,
    input int                n,
    input int                m,
    input logic [31:0][4:0]  tab
  );
    logic [31:0] c;
    logic [31:0] d;
    logic [4:0]  s;
    s = syn[4:0] & 5'((1 << m) - 1);
    c = cw;
    d = '0;
    for (int k = 0; k < 32; k++) begin
      if (k < n && syn[m] && tab[k] == s) c[k] = ~c[k];
    end
    for (int j = 0; j < 32; j++) begin
      if (j < n - m - 1) d[j] = c[j + m + 1];
    end
    return d;
  endfunction

  logic                  s1_valid_q;
  logic [31:0]           s1_cw_q;
  logic [1:0]            s1_mode_q;
  logic [5:0]            s1_syn_q;
  logic                  s2_valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [1:0]            nerr_q;
  logic [5:0]            syn_q;

  logic [31:0] cw_in;
  logic [1:0]  mode_d;
  logic [5:0]  s1_syn_d;
  logic [31:0] s2_data_d;
  logic [1:0]  s2_nerr_d;
  logic        p_s1;
  logic        slow_nz;
  logic        s2_load;
  logic        s1_load;

  assign cw_in = NoisyCodeWord[31:0];
  assign mode_d = (mode == 2'b11) ? 2'b10 : mode;

  always_comb begin
    s2_load = !s2_valid_q || out_ready;
    s1_load = !s1_valid_q || s2_load;
  end

  assign in_ready = s1_load;

  always_comb begin
    s1_syn_d = '0;
    unique case (mode_d)
      2'b00:   s1_syn_d = syn_calc(cw_in, 8, 3, COL3);
      2'b01:   s1_syn_d = syn_calc(cw_in, 16, 4, COL4);
      default: s1_syn_d = syn_calc(cw_in, 32, 5, COL5);
    endcase
  end

  always_comb begin
    s2_data_d = '0;
    p_s1      = 1'b0;
    slow_nz   = 1'b0;
    unique case (s1_mode_q)
      2'b00: begin
        s2_data_d = dec_data(s1_cw_q, s1_syn_q, 8, 3, COL3);
        p_s1      = s1_syn_q[3];
        slow_nz   = |s1_syn_q[2:0];
      end
      2'b01: begin
        s2_data_d = dec_data(s1_cw_q, s1_syn_q, 16, 4, COL4);
        p_s1      = s1_syn_q[4];
        slow_nz   = |s1_syn_q[3:0];
      end
      default: begin
        s2_data_d = dec_data(s1_cw_q, s1_syn_q, 32, 5, COL5);
        p_s1      = s1_syn_q[5];
        slow_nz   = |s1_syn_q[4:0];
      end
    endcase
  end

  always_comb begin
    s2_nerr_d = 2'd0;
    if (p_s1)         s2_nerr_d = 2'd1;
    else if (slow_nz) s2_nerr_d = 2'd2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_cw_q    <= '0;
      s1_mode_q  <= '0;
      s1_syn_q   <= '0;
      s2_valid_q <= 1'b0;
      data_q     <= '0;
      nerr_q     <= '0;
      syn_q      <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_cw_q   <= cw_in;
          s1_mode_q <= mode_d;
          s1_syn_q  <= s1_syn_d;
        end
      end
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          data_q <= DATA_WIDTH'(s2_data_d);
          nerr_q <= s2_nerr_d;
          syn_q  <= s1_syn_q;
        end
      end
    end
  end

  assign out_valid     = s2_valid_q;
  assign data_out      = data_q;
  assign num_of_errors = nerr_q;
  assign syndrome      = syn_q;

`ifdef ECC_DEC_STATS_EN
  logic [15:0] corr_cnt_q;
  logic [15:0] uncorr_cnt_q;
  logic        s2_word;

  assign s2_word = s2_load && s1_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (stat_clr) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (s2_word) begin
      if (s2_nerr_d == 2'd1 && corr_cnt_q != 16'hFFFF)
        corr_cnt_q <= corr_cnt_q + 16'd1;
      if (s2_nerr_d == 2'd2 && uncorr_cnt_q != 16'hFFFF)
        uncorr_cnt_q <= uncorr_cnt_q + 16'd1;
    end
  end

  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
`endif

endmodule

// File: tb/tb_ecc_dec_pipe.sv
// tb_ecc_dec_pipe: randomized self-checking bench for ecc_dec_pipe.
// Reference model encodes random data, injects 0/1/2 bit errors.
module tb_ecc_dec_pipe;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] NoisyCodeWord;
  logic [1:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] data_out;
  logic [1:0]    num_of_errors;
  logic [5:0]    syndrome;
`ifdef ECC_DEC_STATS_EN
  logic          stat_clr;
  logic [15:0]   corr_cnt;
  logic [15:0]   uncorr_cnt;
`endif

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  ne;
    logic [5:0]  syn;
  } exp_t;

  ecc_dec_pipe #(.DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .NoisyCodeWord(NoisyCodeWord),
    .mode(mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out),
    .num_of_errors(num_of_errors),
    .syndrome(syndrome)
`ifdef ECC_DEC_STATS_EN
    ,
    .stat_clr(stat_clr),
    .corr_cnt(corr_cnt),
    .uncorr_cnt(uncorr_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int nbits(input logic [1:0] md);
    return (md == 2'b00) ? 8 : (md == 2'b01) ? 16 : 32;
  endfunction

  function automatic int mbits(input logic [1:0] md);
    return (md == 2'b00) ? 3 : (md == 2'b01) ? 4 : 5;
  endfunction

  function automatic int col(input int k, input logic [1:0] md);
    int m;
    int idx;
    m = mbits(md);
    if (k < m) return 1 << k;
    if (k == m) return 0;
    idx = m + 1;
    for (int v = 3; v < (1 << m); v++) begin
      if ($countones(v) > 1) begin
        if (idx == k) return v;
        idx++;
      end
    end
    return -1;
  endfunction

  function automatic logic [31:0] encode(input logic [31:0] data,
                                         input logic [1:0] md,
                                         input logic [31:0] junk);
    int n, m, s;
    logic [31:0] cw;
    n = nbits(md);
    m = mbits(md);
    cw = '0;
    s = 0;
    for (int j = 0; j < n - m - 1; j++) begin
      if (data[j]) begin
        cw[m + 1 + j] = 1'b1;
        s = s ^ col(m + 1 + j, md);
      end
    end
    for (int k = 0; k < m; k++) cw[k] = ((s >> k) & 1) != 0;
    cw[m] = ^cw;
    for (int k = n; k < 32; k++) cw[k] = junk[k];
    return cw;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] cw,
                                          input logic [1:0] md);
    logic [31:0] d;
    int n, m;
    n = nbits(md);
    m = mbits(md);
    d = '0;
    for (int j = 0; j < n - m - 1; j++) d[j] = cw[m + 1 + j];
    return d;
  endfunction

  task automatic gen_word(input logic [1:0] md, output logic [31:0] cw,
                          output exp_t e);
    int n, m, k, ne, e1, e2, s;
    logic [31:0] data;
    n = nbits(md);
    m = mbits(md);
    k = n - m - 1;
    data = $urandom & ((32'd1 << k) - 32'd1);
    cw = encode(data, md, $urandom);
    ne = int'($urandom_range(0, 2));
    e1 = int'($urandom_range(0, n - 1));
    do e2 = int'($urandom_range(0, n - 1)); while (e2 == e1);
    s = 0;
    if (ne >= 1) begin
      cw[e1] = ~cw[e1];
      s = s ^ col(e1, md);
    end
    if (ne == 2) begin
      cw[e2] = ~cw[e2];
      s = s ^ col(e2, md);
    end
    e.syn = 6'(((ne & 1) << m) | s);
    e.ne = 2'(ne);
    e.d = (ne == 2) ? extract(cw, md) : data;
  endtask

  task automatic run_stream(input int nwords, input bit b2b);
    exp_t q[$];
    exp_t ex, cur_e;
    logic [31:0] cur_cw;
    logic [1:0] cur_md;
    logic [31:0] pd;
    logic [1:0] pn;
    logic [5:0] ps;
    int sent, got, cyc;
    bit stall, saw_block;
    sent = 0;
    got = 0;
    cyc = 0;
    stall = 0;
    saw_block = 0;
    pd = '0;
    pn = '0;
    ps = '0;
    cur_md = b2b ? 2'b10 : 2'($urandom_range(0, 3));
    gen_word(cur_md, cur_cw, cur_e);
    while (got < nwords && cyc < nwords * 20 + 100) begin
      @(negedge clk);
      in_valid = (sent < nwords) && (b2b || $urandom_range(0, 3) != 0);
      NoisyCodeWord = cur_cw;
      mode = cur_md;
      if (b2b) out_ready = !(cyc >= 4 && cyc < 7);
      else out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || data_out !== pd ||
            num_of_errors !== pn || syndrome !== ps) begin
          n_fail++;
          $display("FAIL stall_stable: got v=%b d=%h n=%0d s=%h need v=1 d=%h n=%0d s=%h",
                   out_valid, data_out, num_of_errors, syndrome, pd, pn, ps);
        end
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_output: got d=%h with nothing expected", data_out);
        end else begin
          ex = q.pop_front();
          got++;
          n_checks++;
          if (data_out !== ex.d) begin
            n_fail++;
            $display("FAIL stream_data #%0d: got %h need %h", got, data_out, ex.d);
          end
          n_checks++;
          if (num_of_errors !== ex.ne) begin
            n_fail++;
            $display("FAIL stream_nerr #%0d: got %0d need %0d", got, num_of_errors, ex.ne);
          end
          n_checks++;
          if (syndrome !== ex.syn) begin
            n_fail++;
            $display("FAIL stream_syn #%0d: got %h need %h", got, syndrome, ex.syn);
          end
        end
      end
      stall = out_valid && !out_ready;
      pd = data_out;
      pn = num_of_errors;
      ps = syndrome;
      if (in_valid && !in_ready) saw_block = 1;
      if (in_valid && in_ready) begin
        q.push_back(cur_e);
        sent++;
        cur_md = b2b ? 2'b10 : 2'($urandom_range(0, 3));
        gen_word(cur_md, cur_cw, cur_e);
      end
      cyc++;
    end
    n_checks++;
    if (got != nwords) begin
      n_fail++;
      $display("FAIL stream_count: got %0d words need %0d", got, nwords);
    end
    if (b2b) begin
      n_checks++;
      if (!saw_block) begin
        n_fail++;
        $display("FAIL backpressure: in_ready never low, need low while full");
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    NoisyCodeWord = '0;
    mode = 2'b00;
    out_ready = 1'b1;
`ifdef ECC_DEC_STATS_EN
    stat_clr = 1'b0;
`endif
    #12;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== '0 ||
        num_of_errors !== 2'd0 || syndrome !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b r=%b d=%h n=%0d s=%h need 0 1 0 0 0",
               out_valid, in_ready, data_out, num_of_errors, syndrome);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    logic [31:0] cw_t[7] = '{32'hB1, 32'hF1, 32'hB9, 32'hF0,
                             32'h8000, 32'h8000_0000, 32'hFFFF_FFB1};
    logic [1:0] md_t[7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00};
    logic [31:0] d_t[7] = '{32'hB, 32'hB, 32'hB, 32'hF, 32'h0, 32'h0, 32'hB};
    logic [1:0] n_t[7] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0};
    logic [5:0] s_t[7] = '{6'h00, 6'h0E, 6'h08, 6'h07, 6'h1F, 6'h3F, 6'h00};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      NoisyCodeWord = cw_t[i];
      mode = md_t[i];
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL vec%0d_in_ready: got %b need 1", i, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL vec%0d_early: out_valid got %b need 0", i, out_valid);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || data_out !== d_t[i] ||
          num_of_errors !== n_t[i] || syndrome !== s_t[i]) begin
        n_fail++;
        $display("FAIL vec%0d: got v=%b d=%h n=%0d s=%h need v=1 d=%h n=%0d s=%h",
                 i, out_valid, data_out, num_of_errors, syndrome,
                 d_t[i], n_t[i], s_t[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    run_stream(300, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_stream(8, 1'b1);
  endtask

  task automatic test_reset_midflight();
    bit seen;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    NoisyCodeWord = 32'hB1;
    mode = 2'b00;
    @(negedge clk);
    NoisyCodeWord = 32'hF1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pipe: got v=%b r=%b need v=1 r=0", out_valid, in_ready);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== '0 ||
        num_of_errors !== 2'd0 || syndrome !== 6'd0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b r=%b d=%h n=%0d s=%h need 0 1 0 0 0",
               out_valid, in_ready, data_out, num_of_errors, syndrome);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_discard: got out_valid=1 after reset need 0");
    end
  endtask

`ifdef ECC_DEC_STATS_EN
  task automatic test_stats();
    logic [31:0] w[3] = '{32'hF1, 32'hF0, 32'hF1};
    @(negedge clk);
    n_checks++;
    if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_reset: got %h %h need 0 0", corr_cnt, uncorr_cnt);
    end
    out_ready = 1'b1;
    mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      NoisyCodeWord = w[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (corr_cnt !== 16'd2 || uncorr_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL stats_count: got %0d %0d need 2 1", corr_cnt, uncorr_cnt);
    end
    in_valid = 1'b1;
    NoisyCodeWord = 32'hF1;
    @(negedge clk);
    in_valid = 1'b0;
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    n_checks++;
    if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_clr_prio: got %0d %0d need 0 0", corr_cnt, uncorr_cnt);
    end
    @(negedge clk);
    in_valid = 1'b1;
    NoisyCodeWord = 32'hF1;
    repeat (65540) @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (corr_cnt !== 16'hFFFF || uncorr_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_sat: got %h %h need ffff 0", corr_cnt, uncorr_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_reset_midflight();
`ifdef ECC_DEC_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
